// File: rtl/wk_coef_bank.sv
// Loadable coefficient store: self-initialising RAM with runtime writes and stallable burst reads.
// Optional parity protection is enabled with `define COEF_PARITY_EN.
module wk_coef_bank #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned DEFAULT_W = 2
) (
  input  logic              CS,
  input  logic              rst,
  input  logic              cen,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              wr_inj_err,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              busy,
  output logic [WIDTH-1:0]  Wkp,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              rd_perr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  cnt;
  logic              issue_c;
  logic              accept_c;
  logic              wr_ok_c;
  logic [WIDTH-1:0]  mem [DEPTH];

  // State register
  always_ff @(posedge CS) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  // Next-state and per-cycle control decode
  always_comb begin
    state_nxt = state;
    issue_c   = 1'b0;
    accept_c  = 1'b0;
    wr_ok_c   = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        wr_ok_c = wr_en;
        if (rd_req) begin
          accept_c  = 1'b1;
          state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        wr_ok_c = wr_en;
        if (!cen) begin
          issue_c = 1'b1;
          if (cnt == '0) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Init sweep counter and burst pointer/length
  always_ff @(posedge CS) begin
    if (rst) begin
      init_cnt <= '0;
      ptr      <= '0;
      cnt      <= '0;
    end else begin
      if (state == ST_INIT) init_cnt <= init_cnt + ADDR_W'(1);
      if (accept_c) begin
        ptr <= rd_addr;
        cnt <= rd_len;
      end else if (issue_c) begin
        ptr <= ptr + ADDR_W'(1);
        cnt <= cnt - LEN_W'(1);
      end
    end
  end

  // Single write port shared by the init sweep and runtime writes
  always_ff @(posedge CS) begin
    if (!rst) begin
      if (state == ST_INIT)
        mem[init_cnt] <= (init_cnt == '0) ? '0 : WIDTH'(DEFAULT_W);
      else if (wr_ok_c)
        mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; Wkp holds when nothing is issued
  always_ff @(posedge CS) begin
    if (rst) begin
      Wkp      <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      busy     <= 1'b1;
    end else begin
      if (issue_c) Wkp <= mem[ptr];
      rd_valid <= issue_c;
      rd_last  <= issue_c && (cnt == '0);
      busy     <= (state_nxt != ST_IDLE);
    end
  end

`ifdef COEF_PARITY_EN
  logic par_mem [DEPTH];

  // Even-parity bit per entry; injection stores it inverted
  always_ff @(posedge CS) begin
    if (!rst) begin
      if (state == ST_INIT)
        par_mem[init_cnt] <= (init_cnt == '0) ? 1'b0 : ^(WIDTH'(DEFAULT_W));
      else if (wr_ok_c)
        par_mem[wr_addr] <= (^wr_data) ^ wr_inj_err;
    end
  end

  always_ff @(posedge CS) begin
    if (rst) rd_perr <= 1'b0;
    else     rd_perr <= issue_c && ((^mem[ptr]) != par_mem[ptr]);
  end
`else
  logic unused_inj_err;
  assign unused_inj_err = wr_inj_err;
  assign rd_perr        = 1'b0;
`endif

endmodule

// File: tb/tb_wk_coef_bank.sv
// Randomised self-checking bench for wk_coef_bank against an array model of the coefficient store.
module tb_wk_coef_bank;

  logic       CS = 1'b0;
  logic       rst, cen, wr_en, wr_inj_err, rd_req;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_len;
  logic       busy, rd_valid, rd_last, rd_perr;
  logic [7:0] Wkp;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] model_mem [256];
  bit         model_err [256];
  logic [7:0] exp_wkp;

  wk_coef_bank dut (
    .CS(CS), .rst(rst), .cen(cen), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_inj_err(wr_inj_err), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .busy(busy), .Wkp(Wkp), .rd_valid(rd_valid), .rd_last(rd_last), .rd_perr(rd_perr)
  );

  always #5 CS = ~CS;

  function automatic bit perr_exp(input logic [7:0] a);
`ifdef COEF_PARITY_EN
    return model_err[a];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_init();
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = (i == 0) ? 8'h00 : 8'h02;
      model_err[i] = 1'b0;
    end
    exp_wkp = 8'h00;
  endtask

  task automatic tick();
    @(posedge CS);
    #1;
  endtask

  // Called just after a reset edge; counts busy cycles while poking ignored requests
  task automatic wait_init(input string name);
    int cnt = 0;
    int bad_valid = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      if (rd_valid !== 1'b0) bad_valid++;
      rd_req = 1'b1; rd_addr = 8'h10; rd_len = 8'd3; cen = 1'b0;
      wr_en = 1'b1; wr_addr = 8'h10; wr_data = 8'hEE; wr_inj_err = 1'b1;
      tick();
    end
    rd_req = 1'b0; wr_en = 1'b0; wr_inj_err = 1'b0; cen = 1'b1;
    n_tests++;
    if (cnt != 256) begin
      n_fail++;
      $display("FAIL %s busy_len: busy high %0d cycles, expected 256", name, cnt);
    end
    n_tests++;
    if (bad_valid != 0) begin
      n_fail++;
      $display("FAIL %s init_valid: rd_valid high %0d cycles during init, expected 0", name, bad_valid);
    end
  endtask

  task automatic check_reset_vals(input string name);
    n_tests++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_perr !== 1'b0 || Wkp !== 8'h00) begin
      n_fail++;
      $display("FAIL %s reset_vals: busy=%b valid=%b last=%b perr=%b Wkp=%h, expected 1 0 0 0 00",
               name, busy, rd_valid, rd_last, rd_perr, Wkp);
    end
  endtask

  task automatic write_idle(input logic [7:0] a, input logic [7:0] d, input bit inj);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_inj_err = inj;
    model_mem[a] = d;
    model_err[a] = inj;
    tick();
    wr_en = 1'b0; wr_inj_err = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || Wkp !== exp_wkp) begin
      n_fail++;
      $display("FAIL write_idle @%h: valid=%b busy=%b Wkp=%h, expected 0 0 %h", a, rd_valid, busy, Wkp, exp_wkp);
    end
  endtask

  // One burst from the IDLE state; stall window in loop cycles, optional random traffic
  task automatic do_burst(input logic [7:0] a, input logic [7:0] len, input int stall_lo,
                          input int stall_hi, input bit rnd, input string name, output int gaps);
    int         issued = 0;
    int         cyc = 0;
    bit         iss, el, ep;
    logic [7:0] ew, ptr;
    gaps = 0;
    ptr  = a;
    rd_req = 1'b1; rd_addr = a; rd_len = len; cen = 1'($urandom); wr_en = 1'b0;
    tick();
    rd_req = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b0 || busy !== 1'b1 || Wkp !== exp_wkp) begin
      n_fail++;
      $display("FAIL %s accept: valid=%b busy=%b Wkp=%h, expected 0 1 %h", name, rd_valid, busy, Wkp, exp_wkp);
    end
    while (issued <= int'(len) && cyc < 4000) begin
      cen        = (cyc >= stall_lo && cyc <= stall_hi) || (rnd && $urandom_range(0, 3) == 0);
      rd_req     = rnd ? 1'($urandom) : 1'b0;
      rd_addr    = 8'($urandom);
      rd_len     = 8'($urandom);
      wr_en      = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
      wr_addr    = ($urandom_range(0, 3) == 0) ? ptr : 8'($urandom);
      wr_data    = 8'($urandom);
      wr_inj_err = ($urandom_range(0, 4) == 0);
      iss = !cen;
      ew  = model_mem[ptr];
      ep  = perr_exp(ptr);
      el  = (issued == int'(len));
      if (wr_en) begin
        model_mem[wr_addr] = wr_data;
        model_err[wr_addr] = wr_inj_err;
      end
      tick();
      n_tests++;
      if (iss) begin
        if (rd_valid !== 1'b1 || Wkp !== ew || rd_last !== el || rd_perr !== ep || busy !== !el) begin
          n_fail++;
          $display("FAIL %s word%0d: valid=%b Wkp=%h last=%b perr=%b busy=%b, expected 1 %h %b %b %b",
                   name, issued, rd_valid, Wkp, rd_last, rd_perr, busy, ew, el, ep, !el);
        end
        exp_wkp = ew;
        issued++;
        ptr++;
      end else begin
        if (rd_valid !== 1'b0 || Wkp !== exp_wkp || rd_last !== 1'b0 || rd_perr !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s stall%0d: valid=%b Wkp=%h last=%b perr=%b busy=%b, expected 0 %h 0 0 1",
                   name, cyc, rd_valid, Wkp, rd_last, rd_perr, busy, exp_wkp);
        end
        gaps++;
      end
      cyc++;
    end
    rd_req = 1'b0; wr_en = 1'b0; wr_inj_err = 1'b0; cen = 1'b1;
    if (issued <= int'(len)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: issued %0d words, expected %0d", name, issued, int'(len) + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cen = 1'b1; wr_en = 1'b0; wr_inj_err = 1'b0; rd_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; rd_len = '0;
    tick();
    rst = 1'b0;
    model_init();
    check_reset_vals("reset");
    wait_init("reset");
  endtask

  task automatic test_init_values();
    int g;
    do_burst(8'h00, 8'd3, -1, -1, 1'b0, "init_burst", g);
  endtask

  task automatic test_single();
    int g;
    write_idle(8'h10, 8'hA5, 1'b0);
    do_burst(8'h10, 8'd0, -1, -1, 1'b0, "single", g);
  endtask

  task automatic test_wrap();
    int g;
    write_idle(8'hFF, 8'h11, 1'b0);
    write_idle(8'h00, 8'h22, 1'b0);
    do_burst(8'hFF, 8'd1, -1, -1, 1'b0, "wrap", g);
  endtask

  task automatic test_stall();
    int g;
    do_burst(8'h0E, 8'd7, 2, 4, 1'b0, "stall", g);
    n_tests++;
    if (g != 3) begin
      n_fail++;
      $display("FAIL stall gaps: %0d idle cycles in burst, expected 3", g);
    end
  endtask

  task automatic test_rbw();
    int g;
    rd_req = 1'b1; rd_addr = 8'h20; rd_len = 8'd0;
    tick();
    rd_req = 1'b0; cen = 1'b0;
    wr_en = 1'b1; wr_addr = 8'h20; wr_data = 8'h77; wr_inj_err = 1'b0;
    tick();
    wr_en = 1'b0; cen = 1'b1;
    n_tests++;
    if (rd_valid !== 1'b1 || Wkp !== 8'h02 || rd_last !== 1'b1) begin
      n_fail++;
      $display("FAIL rbw old: valid=%b Wkp=%h last=%b, expected 1 02 1", rd_valid, Wkp, rd_last);
    end
    model_mem[8'h20] = 8'h77;
    model_err[8'h20] = 1'b0;
    exp_wkp = 8'h02;
    do_burst(8'h20, 8'd0, -1, -1, 1'b0, "rbw_reread", g);
  endtask

  task automatic test_back_to_back();
    int g;
    do_burst(8'h40, 8'd2, -1, -1, 1'b1, "b2b_a", g);
    do_burst(8'h43, 8'd4, -1, -1, 1'b1, "b2b_b", g);
  endtask

  task automatic test_parity();
    int g;
    write_idle(8'h05, 8'h3C, 1'b1);
    do_burst(8'h05, 8'd0, -1, -1, 1'b0, "parity_inj", g);
    write_idle(8'h05, 8'h3C, 1'b0);
    do_burst(8'h05, 8'd0, -1, -1, 1'b0, "parity_clean", g);
  endtask

  task automatic test_mid_reset();
    int g;
    rd_req = 1'b1; rd_addr = 8'h08; rd_len = 8'd20; cen = 1'b0;
    tick();
    rd_req = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_init();
    check_reset_vals("mid_reset");
    wait_init("mid_reset");
    do_burst(8'h10, 8'd0, -1, -1, 1'b0, "mid_reset_read", g);
  endtask

  task automatic test_random();
    int         g;
    logic [7:0] a, l;
    for (int i = 0; i < 30; i++) begin
      for (int w = $urandom_range(0, 2); w > 0; w--)
        write_idle(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
      a = 8'($urandom);
      l = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 20));
      do_burst(a, l, -1, -1, 1'b1, "random", g);
    end
  endtask

  initial begin
    test_reset();
    test_init_values();
    test_single();
    test_wrap();
    test_stall();
    test_rbw();
    test_back_to_back();
    test_parity();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
